// File: rtl/ctrl_alu_unit_if.sv
// Decode/ALU bundle for ctrl_alu_unit: IF/ID decode inputs, forwarded operands,
// control outputs to ID/EX and the ALU result to EX/MEM.
interface ctrl_alu_unit_if #(parameter int unsigned WIDTH = 32);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             no_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             reg_dst;
  logic             alu_src;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             reg_write;
  logic             branch;
  logic             branch_n;
  logic             jump;
  logic [1:0]       alu_op;
  logic [2:0]       alu_ctrl;
  logic [2:0]       ex_alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             zero;

  modport slave (
    input  opcode, funct, no_op, a, b,
    output reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write,
           branch, branch_n, jump, alu_op, alu_ctrl, ex_alu_ctrl, alu_result, zero
  );

  modport master (
    output opcode, funct, no_op, a, b,
    input  reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write,
           branch, branch_n, jump, alu_op, alu_ctrl, ex_alu_ctrl, alu_result, zero
  );
endinterface

// File: rtl/ctrl_alu_unit.sv
// MIPS-subset main control, ALU-control decode and ALU with registered EX control.
// Optional ALU_NOR_EN adds funct 100111 -> NOR (ALU code 100).
module ctrl_alu_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  ctrl_alu_unit_if.slave bus
);

  logic       reg_dst, alu_src, mem_read, mem_write, mem_to_reg;
  logic       reg_write, branch, branch_n, jump;
  logic [1:0] alu_op;
  logic [2:0] alu_ctrl;
  logic [2:0] ex_ctrl;
  logic [WIDTH-1:0] result;
  logic             lt;

  always_comb begin
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    branch     = 1'b0;
    branch_n   = 1'b0;
    jump       = 1'b0;
    alu_op     = 2'b00;
    // Reset and stall bubbles both squash every control regardless of opcode.
    if (!rst && !bus.no_op) begin
      case (bus.opcode)
        6'b000000: begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = 2'b10; end
        6'b100011: begin
          alu_src = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1;
        end
        6'b101011: begin alu_src = 1'b1; mem_write = 1'b1; end
        6'b000100: begin branch = 1'b1; alu_op = 2'b01; end
        6'b000101: begin branch_n = 1'b1; alu_op = 2'b01; end
        6'b000010: jump = 1'b1;
        6'b001000: begin alu_src = 1'b1; reg_write = 1'b1; end
        6'b001010: begin alu_src = 1'b1; reg_write = 1'b1; alu_op = 2'b11; end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_ctrl = 3'b010;
    case (alu_op)
      2'b01: alu_ctrl = 3'b110;
      2'b11: alu_ctrl = 3'b111;
      2'b10: begin
        case (bus.funct)
          6'b100010: alu_ctrl = 3'b110;
          6'b100100: alu_ctrl = 3'b000;
          6'b100101: alu_ctrl = 3'b001;
          6'b101010: alu_ctrl = 3'b111;
`ifdef ALU_NOR_EN
          6'b100111: alu_ctrl = 3'b100;
`endif
          default:   alu_ctrl = 3'b010;
        endcase
      end
      default: alu_ctrl = 3'b010;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_ctrl <= 3'b010;
    else     ex_ctrl <= alu_ctrl;
  end

  assign lt = $signed(bus.a) < $signed(bus.b);

  always_comb begin
    result = '0;
    case (ex_ctrl)
      3'b000: result = bus.a & bus.b;
      3'b001: result = bus.a | bus.b;
      3'b010: result = bus.a + bus.b;
      3'b110: result = bus.a - bus.b;
      3'b111: result = {{(WIDTH-1){1'b0}}, lt};
`ifdef ALU_NOR_EN
      3'b100: result = ~(bus.a | bus.b);
`endif
      default: result = '0;
    endcase
  end

  assign bus.reg_dst     = reg_dst;
  assign bus.alu_src     = alu_src;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.reg_write   = reg_write;
  assign bus.branch      = branch;
  assign bus.branch_n    = branch_n;
  assign bus.jump        = jump;
  assign bus.alu_op      = alu_op;
  assign bus.alu_ctrl    = alu_ctrl;
  assign bus.ex_alu_ctrl = ex_ctrl;
  assign bus.alu_result  = result;
  assign bus.zero        = (result == '0);

endmodule

// File: tb/tb_ctrl_alu_unit.sv
// Bench for ctrl_alu_unit: directed vectors with literal expectations plus an
// instruction-level reference model compared every cycle.
module tb_ctrl_alu_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  ctrl_alu_unit_if #(.WIDTH(32)) bus ();
  ctrl_alu_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Flags order: reg_dst alu_src mem_read mem_write mem_to_reg reg_write branch branch_n jump
  typedef struct packed {
    logic [5:0] op;
    logic [8:0] flags;
    logic [1:0] aop;
  } instr_t;

  instr_t isa [8];
  initial begin
    isa[0] = '{6'b000000, 9'b100001000, 2'b10};
    isa[1] = '{6'b100011, 9'b011011000, 2'b00};
    isa[2] = '{6'b101011, 9'b010100000, 2'b00};
    isa[3] = '{6'b000100, 9'b000000100, 2'b01};
    isa[4] = '{6'b000101, 9'b000000010, 2'b01};
    isa[5] = '{6'b000010, 9'b000000001, 2'b00};
    isa[6] = '{6'b001000, 9'b010001000, 2'b00};
    isa[7] = '{6'b001010, 9'b010001000, 2'b11};
  end

  function automatic logic [10:0] m_decode(logic [5:0] op, logic nop, logic r);
    logic [10:0] res = '0;
    if (r || nop) return '0;
    foreach (isa[i]) if (isa[i].op == op) res = {isa[i].flags, isa[i].aop};
    return res;
  endfunction

  function automatic logic [2:0] m_ctrl(logic [1:0] aop, logic [5:0] f);
    if (aop == 2'b01) return 3'b110;
    if (aop == 2'b11) return 3'b111;
    if (aop == 2'b10) begin
      if (f == 6'b100010) return 3'b110;
      if (f == 6'b100100) return 3'b000;
      if (f == 6'b100101) return 3'b001;
      if (f == 6'b101010) return 3'b111;
`ifdef ALU_NOR_EN
      if (f == 6'b100111) return 3'b100;
`endif
    end
    return 3'b010;
  endfunction

  function automatic logic [31:0] m_alu(logic [2:0] c, logic [31:0] x, logic [31:0] y);
    int sx = x;
    int sy = y;
    case (c)
      3'b000: return x & y;
      3'b001: return x | y;
      3'b010: return x + y;
      3'b110: return x - y;
      3'b111: return (sx < sy) ? 32'd1 : 32'd0;
`ifdef ALU_NOR_EN
      3'b100: return ~(x | y);
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [2:0] m_ex;
  logic       m_valid = 1'b0;
  logic [10:0] cur;

  always @(posedge clk or posedge rst) begin
    cur = m_decode(bus.opcode, bus.no_op, rst);
    if (rst) m_ex = 3'b010;
    else     m_ex = m_ctrl(cur[1:0], bus.funct);
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    logic [10:0] d;
    logic [31:0] r;
    if (m_valid) begin
      d = m_decode(bus.opcode, bus.no_op, rst);
      r = m_alu(m_ex, bus.a, bus.b);
      chk("m_flags", 32'({bus.reg_dst, bus.alu_src, bus.mem_read, bus.mem_write,
          bus.mem_to_reg, bus.reg_write, bus.branch, bus.branch_n, bus.jump}), 32'(d[10:2]));
      chk("m_alu_op", 32'(bus.alu_op), 32'(d[1:0]));
      chk("m_alu_ctrl", 32'(bus.alu_ctrl), 32'(m_ctrl(d[1:0], bus.funct)));
      chk("m_ex_ctrl", 32'(bus.ex_alu_ctrl), 32'(m_ex));
      chk("m_result", bus.alu_result, r);
      chk("m_zero", 32'(bus.zero), 32'(r == 32'd0));
    end
  end

  function automatic logic [31:0] flags_now();
    return 32'({bus.reg_dst, bus.alu_src, bus.mem_read, bus.mem_write, bus.mem_to_reg,
                bus.reg_write, bus.branch, bus.branch_n, bus.jump, bus.alu_op});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] ops [10];
  logic [5:0] fns [8];
  logic [31:0] nor_exp;

  initial begin
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0a, 6'h3f, 6'h0d};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h00, 6'h3f};
    bus.opcode = 6'b000000;
    bus.funct  = 6'b100100;
    bus.no_op  = 1'b0;
    bus.a      = 32'd0;
    bus.b      = 32'd0;
    step();
    chk("pre_ex_and", 32'(bus.ex_alu_ctrl), 32'h0);

    // Asynchronous reset with a load opcode on the bus
    bus.opcode = 6'b100011;
    rst = 1'b1;
    #1;
    chk("rst_flags", flags_now(), 32'h0);
    chk("rst_ex", 32'(bus.ex_alu_ctrl), 32'h2);
    chk("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'h2);
    bus.a = 32'd3; bus.b = 32'd4;
    #1;
    chk("rst_add", bus.alu_result, 32'd7);
    step();
    rst = 1'b0;

    // R-type sub
    bus.opcode = 6'b000000; bus.funct = 6'b100010;
    #1;
    chk("rsub_flags", flags_now(), 32'b100001000_10);
    chk("rsub_ctrl", 32'(bus.alu_ctrl), 32'h6);
    step();
    bus.a = 32'd5; bus.b = 32'd7;
    #1;
    chk("rsub_res", bus.alu_result, 32'hFFFF_FFFE);
    chk("rsub_zero", 32'(bus.zero), 32'd0);

    // lw
    bus.opcode = 6'b100011;
    #1;
    chk("lw_flags", flags_now(), 32'b011011000_00);
    step();
    bus.a = 32'h100; bus.b = 32'h8;
    #1;
    chk("lw_res", bus.alu_result, 32'h108);

    // beq / bne
    bus.opcode = 6'b000100;
    #1;
    chk("beq_flags", flags_now(), 32'b000000100_01);
    chk("beq_ctrl", 32'(bus.alu_ctrl), 32'h6);
    step();
    bus.a = 32'd9; bus.b = 32'd9;
    #1;
    chk("beq_zero", 32'(bus.zero), 32'd1);
    bus.opcode = 6'b000101;
    #1;
    chk("bne_flags", flags_now(), 32'b000000010_01);

    // slti, signed compare both directions
    bus.opcode = 6'b001010;
    step();
    bus.a = 32'hFFFF_FFFF; bus.b = 32'd1;
    #1;
    chk("slt_neg", bus.alu_result, 32'd1);
    bus.a = 32'd1; bus.b = 32'hFFFF_FFFF;
    #1;
    chk("slt_pos", bus.alu_result, 32'd0);

    // Stall bubble on a store
    bus.no_op = 1'b1; bus.opcode = 6'b101011;
    #1;
    chk("stall_memw", 32'(bus.mem_write), 32'd0);
    step();
    chk("stall_ex", 32'(bus.ex_alu_ctrl), 32'h2);
    bus.no_op = 1'b0;

    // NOR funct
    bus.opcode = 6'b000000; bus.funct = 6'b100111;
    step();
    bus.a = 32'd0; bus.b = 32'd0;
    #1;
`ifdef ALU_NOR_EN
    nor_exp = 32'hFFFF_FFFF;
`else
    nor_exp = 32'h0;
`endif
    chk("nor_res", bus.alu_result, nor_exp);

    // Mixed vectors checked by the model, with one reset pulse in the middle
    for (int i = 0; i < 60; i++) begin
      bus.opcode = ops[$urandom_range(0, 9)];
      bus.funct  = fns[$urandom_range(0, 7)];
      bus.no_op  = ($urandom_range(0, 7) == 0);
      bus.a      = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      bus.b      = (i % 7 == 0) ? bus.a : $urandom;
      rst        = (i == 30);
      step();
    end
    rst = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout got running want finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
